vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised, runtime-reprogrammable raster timing generator; next generation of the fixed 640x480 timing block.
//  Produces hcount/vcount, hsync/vsync with per-mode polarity, de, and line/frame start strobes, all registered and
//  mutually aligned. Feeds the pixel pipeline and VGA output stage. New timings are accepted via valid/ready and
//  applied only at a frame boundary, so no torn frames.
// PARAMETERS
//  CW        10   counter/config field width (bits)
//  H_ACT     640  reset-default horizontal visible pixels
//  H_FP      16   reset-default horizontal front porch
//  H_SW      96   reset-default hsync pulse width
//  H_BP      48   reset-default horizontal back porch
//  V_ACT     480  reset-default visible lines
//  V_FP      10   reset-default vertical front porch
//  V_SW      2    reset-default vsync pulse width
//  V_BP      33   reset-default vertical back porch
//  HS_POL    0    reset-default hsync active level (0 = active-low)
//  VS_POL    0    reset-default vsync active level
// PORTS
//  clk_pix       in   1     pixel clock; sole clock
//  resetn        in   1     synchronous, active-high reset (1 = reset)
//  pix_ce        in   1     advance enable; 0 freezes all state and outputs
//  cfg_valid     in   1     new timing set offered
//  cfg_ready     out  1     generator can accept a timing set
//  cfg_h_act/fp/sw/bp  in  CW each  horizontal fields
//  cfg_v_act/fp/sw/bp  in  CW each  vertical fields
//  cfg_hs_pol    in   1     hsync active level
//  cfg_vs_pol    in   1     vsync active level
//  cfg_err       out  1     one-cycle pulse: offered set rejected
//  hcount        out  CW    pixel x of current output cycle
//  vcount        out  CW    line y of current output cycle
//  hsync, vsync  out  1     sync at programmed polarity
//  de            out  1     visible-area enable
//  line_start    out  1     high on hcount==0 output cycle
//  frame_start   out  1     high on hcount==0 && vcount==0 output cycle
// BEHAVIOUR
//  - Reset: active set <= parameter defaults; counters 0; pending empty; cfg_ready=1; cfg_err=0; hcount=vcount=0;
//    de=0; line_start=frame_start=0; hsync=~HS_POL, vsync=~VS_POL. Reset wins over every other input.
//  - Totals HT = act+fp+sw+bp, VT likewise, computed CW+2 bits wide. h counter wraps at HT-1, v increments on
//    h wrap and wraps at VT-1; advance only when pix_ce=1.
//  - Outputs are registered from counter state with exactly 1 cycle latency; all outputs describe the same (h,v).
//    hsync active for act+fp <= h < act+fp+sw; vsync likewise on v; de = h<act && v<act_v.
//  - pix_ce=0: counters, hcount/vcount/syncs/de hold; line_start/frame_start forced 0 (no duplicated strobes).
//  - Handshake: transfer on cfg_valid && cfg_ready. Set rejected (cfg_err=1 next cycle, nothing stored, cfg_ready
//    stays 1) if any act or sw field is 0, or HT > 2^CW, or VT > 2^CW. Accepted set goes to pending; cfg_ready=0.
//  - Apply: on the cycle counters wrap from (HT-1,VT-1) with pix_ce=1, pending -> active, counters -> 0; cfg_ready
//    returns 1 the following cycle. First output of new mode is frame_start with new polarities.
//  - Transfer in the same cycle as the frame wrap: stored as pending, applied at the NEXT frame wrap.
//  - cfg inputs are ignored while cfg_ready=0; cfg_valid need not drop after rejection.
//  - Reset mid-frame or with pending set: pending discarded, defaults restored.
//  - FP or BP of 0 is legal (sync abuts visible area / wrap).
// TESTING
//  1 Reset, pix_ce=1, default params -> 800 clk per line, 525 lines; hsync low h=656..751; vsync low v=490..491;
//    de count 307200 per frame; frame_start every 420000 cycles.
//  2 Mid-frame offer 4x2 visible, fp/sw/bp=1, pol=1 -> cfg_ready drops, old timing until wrap; then HT=7, VT=5,
//    hsync high only at h=5, frame_start after wrap, cfg_ready=1 next cycle.
//  3 Offer cfg_h_act=0, then HT=1025 (CW=10) -> cfg_err pulse each, cfg_ready stays 1, timing unchanged.
//  4 Toggle pix_ce 1/0 alternating -> output sequence equals case 1 at half rate; strobes never two consecutive cycles.
//  5 Transfer on exact wrap cycle -> current frame keeps old timing, new timing applied one frame later.
//  6 Assert resetn mid-line with pending set -> next cycle all outputs at reset values, defaults restored, cfg_ready=1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Runtime-reprogrammable raster timing generator. It accepts new timing sets over
// valid/ready and swaps them in only at a frame wrap. All outputs are registered.
module vga_timing_gen #(
  parameter int CW     = 10,
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int H_SW   = 96,
  parameter int H_BP   = 48,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10,
  parameter int V_SW   = 2,
  parameter int V_BP   = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic          clk_pix,
  input  logic          resetn,
  input  logic          pix_ce,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_h_act,
  input  logic [CW-1:0] cfg_h_fp,
  input  logic [CW-1:0] cfg_h_sw,
  input  logic [CW-1:0] cfg_h_bp,
  input  logic [CW-1:0] cfg_v_act,
  input  logic [CW-1:0] cfg_v_fp,
  input  logic [CW-1:0] cfg_v_sw,
  input  logic [CW-1:0] cfg_v_bp,
  input  logic          cfg_hs_pol,
  input  logic          cfg_vs_pol,
  output logic          cfg_err,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
);

  localparam int TW = CW + 2;

  typedef struct packed {
    logic [CW-1:0] h_act, h_fp, h_sw, h_bp;
    logic [CW-1:0] v_act, v_fp, v_sw, v_bp;
    logic          hs_pol, vs_pol;
  } timing_t;

  timing_t       dflt_cfg, cfg_in, act_cfg, pend_cfg;
  logic          pend_valid;
  logic [CW-1:0] h_cnt, v_cnt;
  logic [TW-1:0] h_tot, v_tot, in_h_tot, in_v_tot;
  logic [TW-1:0] h_sync_beg, h_sync_end, v_sync_beg, v_sync_end;
  logic          h_last, v_last, in_hs, in_vs, in_de;
  logic          cfg_bad, cfg_fire;

  assign dflt_cfg = '{h_act: CW'(H_ACT), h_fp: CW'(H_FP), h_sw: CW'(H_SW), h_bp: CW'(H_BP),
                      v_act: CW'(V_ACT), v_fp: CW'(V_FP), v_sw: CW'(V_SW), v_bp: CW'(V_BP),
                      hs_pol: HS_POL, vs_pol: VS_POL};

  assign cfg_in = '{h_act: cfg_h_act, h_fp: cfg_h_fp, h_sw: cfg_h_sw, h_bp: cfg_h_bp,
                    v_act: cfg_v_act, v_fp: cfg_v_fp, v_sw: cfg_v_sw, v_bp: cfg_v_bp,
                    hs_pol: cfg_hs_pol, vs_pol: cfg_vs_pol};

  // Totals are two bits wider than the fields so four maximal fields cannot overflow.
  assign h_tot      = TW'(act_cfg.h_act) + TW'(act_cfg.h_fp) + TW'(act_cfg.h_sw) + TW'(act_cfg.h_bp);
  assign v_tot      = TW'(act_cfg.v_act) + TW'(act_cfg.v_fp) + TW'(act_cfg.v_sw) + TW'(act_cfg.v_bp);
  assign h_sync_beg = TW'(act_cfg.h_act) + TW'(act_cfg.h_fp);
  assign h_sync_end = h_sync_beg + TW'(act_cfg.h_sw);
  assign v_sync_beg = TW'(act_cfg.v_act) + TW'(act_cfg.v_fp);
  assign v_sync_end = v_sync_beg + TW'(act_cfg.v_sw);

  assign h_last = (TW'(h_cnt) == h_tot - TW'(1));
  assign v_last = (TW'(v_cnt) == v_tot - TW'(1));
  assign in_hs  = (TW'(h_cnt) >= h_sync_beg) && (TW'(h_cnt) < h_sync_end);
  assign in_vs  = (TW'(v_cnt) >= v_sync_beg) && (TW'(v_cnt) < v_sync_end);
  assign in_de  = (h_cnt < act_cfg.h_act) && (v_cnt < act_cfg.v_act);

  assign in_h_tot = TW'(cfg_h_act) + TW'(cfg_h_fp) + TW'(cfg_h_sw) + TW'(cfg_h_bp);
  assign in_v_tot = TW'(cfg_v_act) + TW'(cfg_v_fp) + TW'(cfg_v_sw) + TW'(cfg_v_bp);
  assign cfg_bad  = (cfg_h_act == '0) || (cfg_v_act == '0) || (cfg_h_sw == '0) || (cfg_v_sw == '0) ||
                    (in_h_tot > (TW'(1) << CW)) || (in_v_tot > (TW'(1) << CW));

  assign cfg_ready = !pend_valid;
  assign cfg_fire  = cfg_valid && cfg_ready;

  // A set is only ever accepted while nothing is pending and only ever applied while
  // something is pending, so the two pend_valid updates below never collide.
  always_ff @(posedge clk_pix) begin
    if (resetn) begin
      act_cfg     <= dflt_cfg;
      pend_cfg    <= dflt_cfg;
      pend_valid  <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      cfg_err     <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      cfg_err     <= cfg_fire && cfg_bad;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (cfg_fire && !cfg_bad) begin
        pend_cfg   <= cfg_in;
        pend_valid <= 1'b1;
      end
      if (pix_ce) begin
        hcount      <= h_cnt;
        vcount      <= v_cnt;
        hsync       <= in_hs ? act_cfg.hs_pol : ~act_cfg.hs_pol;
        vsync       <= in_vs ? act_cfg.vs_pol : ~act_cfg.vs_pol;
        de          <= in_de;
        line_start  <= (h_cnt == '0);
        frame_start <= (h_cnt == '0) && (v_cnt == '0);
        if (h_last) begin
          h_cnt <= '0;
          if (v_last) begin
            v_cnt <= '0;
            if (pend_valid) begin
              act_cfg    <= pend_cfg;
              pend_valid <= 1'b0;
            end
          end else begin
            v_cnt <= v_cnt + CW'(1);
          end
        end else begin
          h_cnt <= h_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: two generator instances (640x480 defaults and a tiny default
// mode) checked every cycle against a behavioural scoreboard plus hand-derived checks.
module tb_vga_timing_gen;

  localparam int CW = 10;

  typedef struct packed {
    logic [CW-1:0] h_act, h_fp, h_sw, h_bp;
    logic [CW-1:0] v_act, v_fp, v_sw, v_bp;
    logic          hs_pol, vs_pol;
  } timing_t;

  typedef struct packed {
    logic          ready, err;
    logic [CW-1:0] hc, vc;
    logic          hs, vs, de, ls, fs;
  } out_t;

  typedef struct {
    timing_t dflt, act, pend;
    logic    pend_v;
    int      h, v;
    out_t    o;
  } model_t;

  typedef struct {
    timing_t t;
    logic    exp_err;
    logic    exp_ready;
  } vec_t;

  logic          clk_pix = 1'b0;
  logic          resetn, pix_ce, cfg_valid;
  timing_t       cfg;
  logic          cfg_ready[2], cfg_err[2], hsync[2], vsync[2], de[2], line_start[2], frame_start[2];
  logic [CW-1:0] hcount[2], vcount[2];

  model_t mdl[2];
  out_t   exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;

  always #5 clk_pix = ~clk_pix;

  vga_timing_gen u_dflt (
    .clk_pix(clk_pix), .resetn(resetn), .pix_ce(pix_ce), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready[0]),
    .cfg_h_act(cfg.h_act), .cfg_h_fp(cfg.h_fp), .cfg_h_sw(cfg.h_sw), .cfg_h_bp(cfg.h_bp),
    .cfg_v_act(cfg.v_act), .cfg_v_fp(cfg.v_fp), .cfg_v_sw(cfg.v_sw), .cfg_v_bp(cfg.v_bp),
    .cfg_hs_pol(cfg.hs_pol), .cfg_vs_pol(cfg.vs_pol), .cfg_err(cfg_err[0]),
    .hcount(hcount[0]), .vcount(vcount[0]), .hsync(hsync[0]), .vsync(vsync[0]), .de(de[0]),
    .line_start(line_start[0]), .frame_start(frame_start[0])
  );

  vga_timing_gen #(
    .H_ACT(8), .H_FP(2), .H_SW(3), .H_BP(3), .V_ACT(4), .V_FP(1), .V_SW(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1)
  ) u_small (
    .clk_pix(clk_pix), .resetn(resetn), .pix_ce(pix_ce), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready[1]),
    .cfg_h_act(cfg.h_act), .cfg_h_fp(cfg.h_fp), .cfg_h_sw(cfg.h_sw), .cfg_h_bp(cfg.h_bp),
    .cfg_v_act(cfg.v_act), .cfg_v_fp(cfg.v_fp), .cfg_v_sw(cfg.v_sw), .cfg_v_bp(cfg.v_bp),
    .cfg_hs_pol(cfg.hs_pol), .cfg_vs_pol(cfg.vs_pol), .cfg_err(cfg_err[1]),
    .hcount(hcount[1]), .vcount(vcount[1]), .hsync(hsync[1]), .vsync(vsync[1]), .de(de[1]),
    .line_start(line_start[1]), .frame_start(frame_start[1])
  );

  function automatic timing_t mk_t(input int ha, hf, hs, hb, va, vf, vs, vb, input bit hp, vp);
    timing_t t;
    t = '{h_act: CW'(ha), h_fp: CW'(hf), h_sw: CW'(hs), h_bp: CW'(hb),
          v_act: CW'(va), v_fp: CW'(vf), v_sw: CW'(vs), v_bp: CW'(vb), hs_pol: hp, vs_pol: vp};
    return t;
  endfunction

  function automatic out_t get_actual(input int k);
    out_t a;
    a = '{ready: cfg_ready[k], err: cfg_err[k], hc: hcount[k], vc: vcount[k], hs: hsync[k],
          vs: vsync[k], de: de[k], ls: line_start[k], fs: frame_start[k]};
    return a;
  endfunction

  // Behavioural reference: predicts the outputs visible right after the next edge.
  function automatic void model_step(input int k);
    model_t m;
    logic   old_pend;
    int     ht, vt, hsb, hse, vsb, vse, nht, nvt;
    m        = mdl[k];
    old_pend = m.pend_v;
    if (resetn) begin
      m.act    = m.dflt;
      m.pend_v = 1'b0;
      m.h      = 0;
      m.v      = 0;
      m.o      = '{ready: 1'b1, err: 1'b0, hc: '0, vc: '0, hs: ~m.dflt.hs_pol, vs: ~m.dflt.vs_pol,
                   de: 1'b0, ls: 1'b0, fs: 1'b0};
    end else begin
      ht  = int'(m.act.h_act) + int'(m.act.h_fp) + int'(m.act.h_sw) + int'(m.act.h_bp);
      vt  = int'(m.act.v_act) + int'(m.act.v_fp) + int'(m.act.v_sw) + int'(m.act.v_bp);
      hsb = int'(m.act.h_act) + int'(m.act.h_fp);
      hse = hsb + int'(m.act.h_sw);
      vsb = int'(m.act.v_act) + int'(m.act.v_fp);
      vse = vsb + int'(m.act.v_sw);
      m.o.err = 1'b0;
      if (pix_ce) begin
        m.o.hc = CW'(m.h);
        m.o.vc = CW'(m.v);
        m.o.hs = (m.h >= hsb && m.h < hse) ? m.act.hs_pol : ~m.act.hs_pol;
        m.o.vs = (m.v >= vsb && m.v < vse) ? m.act.vs_pol : ~m.act.vs_pol;
        m.o.de = (m.h < int'(m.act.h_act)) && (m.v < int'(m.act.v_act));
        m.o.ls = (m.h == 0);
        m.o.fs = (m.h == 0) && (m.v == 0);
        if (m.h == ht - 1) begin
          m.h = 0;
          if (m.v == vt - 1) begin
            m.v = 0;
            if (old_pend) begin
              m.act    = m.pend;
              m.pend_v = 1'b0;
            end
          end else begin
            m.v = m.v + 1;
          end
        end else begin
          m.h = m.h + 1;
        end
      end else begin
        m.o.ls = 1'b0;
        m.o.fs = 1'b0;
      end
      if (cfg_valid && !old_pend) begin
        nht = int'(cfg.h_act) + int'(cfg.h_fp) + int'(cfg.h_sw) + int'(cfg.h_bp);
        nvt = int'(cfg.v_act) + int'(cfg.v_fp) + int'(cfg.v_sw) + int'(cfg.v_bp);
        if (cfg.h_act == 0 || cfg.v_act == 0 || cfg.h_sw == 0 || cfg.v_sw == 0 ||
            nht > 1024 || nvt > 1024) begin
          m.o.err = 1'b1;
        end else begin
          m.pend   = cfg;
          m.pend_v = 1'b1;
        end
      end
      m.o.ready = !m.pend_v;
    end
    mdl[k] = m;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One clock: predict, push, clock, then pop and compare both instances.
  task automatic apply_stimulus();
    out_t e;
    for (int k = 0; k < 2; k++) begin
      model_step(k);
      exp_q.push_back(mdl[k].o);
    end
    @(posedge clk_pix);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      check_output($sformatf("scoreboard dut%0d cyc%0d", k, cyc), 32'(get_actual(k)), 32'(e));
    end
  endtask

  task automatic wait_frame(input int k, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      apply_stimulus();
      if (frame_start[k]) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] aborted by watchdog");
  end

  initial begin
    vec_t tab[8];
    int   de_cnt, hs_cnt, hs_min, hs_max, ls_cnt, fs_cnt, ls_gap, last_ls, fs_gap, last_fs, n, dbl;
    logic found, prev_ls, prev_fs;

    tab[0] = '{t: mk_t(0, 16, 96, 48, 480, 10, 2, 33, 0, 0),        exp_err: 1'b1, exp_ready: 1'b1};
    tab[1] = '{t: mk_t(640, 16, 96, 48, 0, 10, 2, 33, 0, 0),        exp_err: 1'b1, exp_ready: 1'b1};
    tab[2] = '{t: mk_t(640, 16, 0, 48, 480, 10, 2, 33, 0, 0),       exp_err: 1'b1, exp_ready: 1'b1};
    tab[3] = '{t: mk_t(640, 16, 96, 48, 480, 10, 0, 33, 0, 0),      exp_err: 1'b1, exp_ready: 1'b1};
    tab[4] = '{t: mk_t(640, 16, 96, 273, 480, 10, 2, 33, 0, 0),     exp_err: 1'b1, exp_ready: 1'b1};
    tab[5] = '{t: mk_t(640, 16, 96, 48, 480, 10, 2, 533, 0, 0),     exp_err: 1'b1, exp_ready: 1'b1};
    tab[6] = '{t: mk_t(1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023, 1, 1), exp_err: 1'b1, exp_ready: 1'b1};
    tab[7] = '{t: mk_t(640, 16, 96, 272, 480, 10, 2, 33, 1, 1),     exp_err: 1'b0, exp_ready: 1'b0};

    mdl[0].dflt = mk_t(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    mdl[1].dflt = mk_t(8, 2, 3, 3, 4, 1, 2, 1, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      mdl[k].act    = mdl[k].dflt;
      mdl[k].pend   = mdl[k].dflt;
      mdl[k].pend_v = 1'b0;
      mdl[k].h      = 0;
      mdl[k].v      = 0;
      mdl[k].o      = '0;
    end

    resetn    = 1'b1;
    pix_ce    = 1'b1;
    cfg_valid = 1'b0;
    cfg       = '0;
    repeat (2) apply_stimulus();
    check_output("reset dflt", 32'(get_actual(0)),
                 32'(out_t'{1'b1, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
    check_output("reset small", 32'(get_actual(1)),
                 32'(out_t'{1'b1, 1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));

    // Default 640x480 timing over the first two lines.
    resetn = 1'b0;
    de_cnt = 0; hs_cnt = 0; hs_min = 9999; hs_max = -1; ls_cnt = 0; fs_cnt = 0;
    ls_gap = 0; last_ls = -1; fs_gap = 0; last_fs = -1;
    for (int i = 0; i < 1600; i++) begin
      apply_stimulus();
      if (de[0]) de_cnt++;
      if (!hsync[0]) begin
        hs_cnt++;
        if (int'(hcount[0]) < hs_min) hs_min = int'(hcount[0]);
        if (int'(hcount[0]) > hs_max) hs_max = int'(hcount[0]);
      end
      if (line_start[0]) begin
        if (last_ls >= 0) ls_gap = i - last_ls;
        last_ls = i;
        ls_cnt++;
      end
      if (frame_start[0]) fs_cnt++;
      if (frame_start[1]) begin
        if (last_fs >= 0) fs_gap = i - last_fs;
        last_fs = i;
      end
    end
    check_output("de count 2 lines", 32'(de_cnt), 32'd1280);
    check_output("hsync low count", 32'(hs_cnt), 32'd192);
    check_output("hsync low first h", 32'(hs_min), 32'd656);
    check_output("hsync low last h", 32'(hs_max), 32'd751);
    check_output("line_start count", 32'(ls_cnt), 32'd2);
    check_output("line period", 32'(ls_gap), 32'd800);
    check_output("frame_start count", 32'(fs_cnt), 32'd1);
    check_output("small frame period", 32'(fs_gap), 32'd128);

    // Offer table: invalid sets bounce with cfg_err, the last one is accepted.
    for (int i = 0; i < 8; i++) begin
      cfg       = tab[i].t;
      cfg_valid = 1'b1;
      apply_stimulus();
      cfg_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
        check_output($sformatf("vec%0d dut%0d cfg_err", i, k), 32'(cfg_err[k]), 32'(tab[i].exp_err));
        check_output($sformatf("vec%0d dut%0d cfg_ready", i, k), 32'(cfg_ready[k]), 32'(tab[i].exp_ready));
      end
    end
    apply_stimulus();
    check_output("cfg_err single pulse", 32'(cfg_err[0]), 32'd0);

    // Reset mid-line with a pending set.
    repeat (37) apply_stimulus();
    resetn = 1'b1;
    apply_stimulus();
    check_output("mid reset dflt", 32'(get_actual(0)),
                 32'(out_t'{1'b1, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
    check_output("mid reset small", 32'(get_actual(1)),
                 32'(out_t'{1'b1, 1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
    resetn = 1'b0;
    apply_stimulus();
    check_output("after reset frame_start", 32'({frame_start[0], hcount[0], vcount[0]}), 32'({1'b1, 20'd0}));

    // Mid-frame offer of a 4x2 mode with positive syncs on the small instance.
    repeat (50) apply_stimulus();
    cfg       = mk_t(4, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b1);
    cfg_valid = 1'b1;
    apply_stimulus();
    cfg_valid = 1'b0;
    check_output("4x2 accepted ready low", 32'(cfg_ready[1]), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      apply_stimulus();
      if (frame_start[1]) found = 1'b1;
    end
    check_output("4x2 frame_start seen", 32'(found), 32'd1);
    check_output("4x2 first output", 32'({cfg_ready[1], hsync[1], vsync[1], hcount[1], vcount[1]}),
                 32'({1'b1, 1'b0, 1'b0, 20'd0}));
    hs_cnt = 0; hs_max = 0; ls_cnt = 0; de_cnt = 0;
    for (int i = 0; i < 35; i++) begin
      if (i > 0) apply_stimulus();
      if (hsync[1]) begin
        hs_cnt++;
        if (hcount[1] != 10'd5) hs_max++;
      end
      if (line_start[1]) ls_cnt++;
      if (de[1]) de_cnt++;
    end
    check_output("4x2 hsync high count", 32'(hs_cnt), 32'd5);
    check_output("4x2 hsync off h=5", 32'(hs_max), 32'd0);
    check_output("4x2 line count", 32'(ls_cnt), 32'd5);
    check_output("4x2 de count", 32'(de_cnt), 32'd8);
    apply_stimulus();
    check_output("4x2 frame period", 32'(frame_start[1]), 32'd1);

    // Transfer on the exact wrap cycle: old 7x5 frame first, then the new 4x4 one.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      apply_stimulus();
      if (hcount[1] == 10'd5 && vcount[1] == 10'd4) found = 1'b1;
    end
    check_output("reach (5,4)", 32'(found), 32'd1);
    cfg       = mk_t(3, 0, 1, 0, 2, 0, 1, 1, 1'b0, 1'b0);
    cfg_valid = 1'b1;
    apply_stimulus();
    cfg_valid = 1'b0;
    check_output("wrap offer", 32'({hcount[1], vcount[1], cfg_ready[1]}), 32'({10'd6, 10'd4, 1'b0}));
    apply_stimulus();
    check_output("wrap old frame start", 32'({frame_start[1], cfg_ready[1]}), 32'({1'b1, 1'b0}));
    wait_frame(1, 100, n);
    check_output("old frame length", 32'(n), 32'd35);
    check_output("ready after apply", 32'(cfg_ready[1]), 32'd1);
    wait_frame(1, 100, n);
    check_output("new frame length", 32'(n), 32'd16);

    // Alternating pix_ce: half rate, strobes never on back-to-back cycles.
    dbl = 0; fs_cnt = 0; prev_ls = 1'b0; prev_fs = 1'b0;
    for (int i = 0; i < 128; i++) begin
      pix_ce = (i % 2 == 0);
      apply_stimulus();
      if (line_start[1] && prev_ls) dbl++;
      if (frame_start[1] && prev_fs) dbl++;
      if (frame_start[1]) fs_cnt++;
      prev_ls = line_start[1];
      prev_fs = frame_start[1];
    end
    pix_ce = 1'b1;
    check_output("pix_ce strobe repeats", 32'(dbl), 32'd0);
    check_output("pix_ce frame count", 32'(fs_cnt), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
